pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Companion to the board PLL wrappers (EHXPLLL instances built with PLLRST_ENA enabled).
- Drives PLL RST and watches its LOCK output, filtering glitches and retrying when lock times out.
- Releases NUM_RST staggered active-high domain resets once lock is stable.
- Runs entirely in the PLL input clock domain; each consumer re-synchronises its rst_out bit into its own domain.

Parameters:
- NUM_RST, 3: number of downstream reset channels (1..8).
- RST_PULSE, 16: cycles pll_rst is held high per attempt (>=2).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry (>=4).
- LOCK_STABLE, 1024: consecutive synchronised-lock-high cycles required (>=1).
- STAGGER, 16: cycles between successive channel releases (>=1).
- MAX_RETRY, 3: PLL reset retries before declaring failure (0..255).

Ports:
- clkin  in  1  reference clock, same net as the PLL's clkin.
- rst_n  in  1  asynchronous, active-low reset.
- locked  in  1  raw PLL LOCK, asynchronous.
- pll_rst  out  1  to PLL RST, active high.
- rst_out  out  NUM_RST  per-domain resets, active high; bit 0 releases first.
- ready  out  1  high when all channels are released and lock is held.
- fail  out  1  sticky; set once retries are exhausted.
- retry_cnt  out  8  number of PLL resets issued since the last RUN entry.

Behaviour:
- Async reset (rst_n low), all registered outputs:
  - state=RESET_PLL, pll_rst=1, rst_out=all ones, ready=0, fail=0, retry_cnt=0.
  - All counters=0; lock synchroniser flops=0.
- locked passes through a 2-flop synchroniser to give lock_s; all decisions use lock_s.
- RESET_PLL:
  - pll_rst=1; counter runs 0..RST_PULSE-1.
  - At RST_PULSE-1: go to WAIT_LOCK, timer cleared.
- WAIT_LOCK:
  - pll_rst=0; timer increments.
  - lock_s=1: go to STABLE, counter=0. Lock takes priority over timeout in the same cycle.
  - Else timer==LOCK_TIMEOUT-1 and retry_cnt==MAX_RETRY: go to FAIL.
  - Else timer==LOCK_TIMEOUT-1: retry_cnt+1, go to RESET_PLL.
- STABLE:
  - lock_s=0: go to WAIT_LOCK, timer cleared.
  - Counter reaches LOCK_STABLE-1 with lock_s=1: go to RELEASE, counter=0.
- RELEASE:
  - Counter increments each cycle.
  - When counter==(i+1)*STAGGER-1, rst_out[i] clears on the next edge.
  - After the last channel clears: go to RUN; ready=1 on the same edge; retry_cnt=0.
- RUN: hold state. Outputs stay put until lock_s drops.
- Loss of lock (lock_s=0 in RELEASE or RUN):
  - Next edge: rst_out=all ones, ready=0, go to WAIT_LOCK.
  - No PLL reset is issued; retry_cnt is not incremented.
- FAIL:
  - pll_rst=0, rst_out=all ones, fail=1, ready=0.
  - Terminal until rst_n; lock_s is ignored.
- Widths:
  - Counters are sized with $clog2 of the maximum terminal value: max(RST_PULSE, LOCK_TIMEOUT, LOCK_STABLE, NUM_RST*STAGGER).
  - Counters never wrap, because every terminal compare forces a state change.
- Latency: raw locked rising to first rst_out bit low = 2 + LOCK_STABLE + STAGGER cycles (+1 for the registered output).
- Reset mid-operation: rst_n low forces the reset values asynchronously in any state, including mid-RELEASE.

Optional Feature:
- Macro: PLL_SEQ_RELOCK_CNT_EN.
- Defined:
  - Adds output relock_cnt[15:0].
  - Increments (saturating at 16'hFFFF) on every loss-of-lock exit from RELEASE or RUN.
  - Cleared only by rst_n.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum (RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL), 3-bit encoding;
  - the counter-width function.
- One natural sub-module, sync2: the 2-flop async-reset synchroniser, reused for locked. Downstream consumers reuse the same sub-module for rst_out.

Test Plan (overrides: RST_PULSE=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, STAGGER=4, NUM_RST=3, MAX_RETRY=2):
- Clean lock: locked rises at cycle 10 after reset release -> pll_rst low after 4 cycles; rst_out 111->110->100->000 at 4-cycle spacing, first change 2+8+4+1 cycles after the rise; ready=1 with 000.
- Glitchy lock: locked high 5 cycles, low 1, then high -> STABLE restarts; no rst_out change until 8 consecutive lock_s cycles.
- Timeout retry: locked held low -> pll_rst pulses of 4 cycles every 4+32 cycles; retry_cnt 1, 2; fail=1 after the third timeout; pll_rst=0, rst_out=111 thereafter.
- Loss in RUN: drop locked for 3 cycles -> rst_out=111 and ready=0 within 3 cycles; full re-release with no pll_rst pulse; relock_cnt=1 when the macro is defined.
- Reset mid-RELEASE: assert rst_n after rst_out=110 -> immediately rst_out=111, pll_rst=1, retry_cnt=0.
- Simultaneous: lock_s rises on the same cycle timer hits 31 -> STABLE entered; retry_cnt unchanged.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: FSM state encoding and
// the helper that sizes the single shared phase counter.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } seq_state_e;

  // Width needed to hold the largest terminal count of any phase.
  function automatic int cnt_width(input int rst_pulse, input int lock_timeout,
                                   input int lock_stable, input int release_span);
    int m;
    m = rst_pulse;
    if (lock_timeout > m) m = lock_timeout;
    if (lock_stable > m) m = lock_stable;
    if (release_span > m) m = release_span;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop asynchronous-reset synchroniser. It brings PLL lock into the
// sequencer's domain, and consumers reuse it to re-time their rst_out bit.
module sync2 #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: flops use non-blocking assignments so both stages sample the
  // pre-edge values; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {WIDTH{RST_VAL}};
      sync_q <= {WIDTH{RST_VAL}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer with glitch filtering, timeout retry and staggered
// reset release. Define PLL_SEQ_RELOCK_CNT_EN to add the relock_cnt output.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_RST      = 3,
  parameter int RST_PULSE    = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int STAGGER      = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  logic               locked,
  output logic               pll_rst,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic               fail,
  output logic [7:0]         retry_cnt
`ifdef PLL_SEQ_RELOCK_CNT_EN
  ,
  output logic [15:0]        relock_cnt
`endif
);

  localparam int CW = cnt_width(RST_PULSE, LOCK_TIMEOUT, LOCK_STABLE, NUM_RST * STAGGER);

  localparam logic [CW-1:0] PULSE_END   = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] TIMEOUT_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_END  = CW'(LOCK_STABLE - 1);
  localparam logic [7:0]    RETRY_MAX   = 8'(MAX_RETRY);

  seq_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic               pll_rst_q;
  logic [NUM_RST-1:0] rst_out_q;
  logic               ready_q;
  logic               fail_q;
  logic [7:0]         retry_q;
  logic               lock_s;
  logic [NUM_RST-1:0] rel_hit;
  logic               lock_lost;
`ifdef PLL_SEQ_RELOCK_CNT_EN
  logic [15:0]        relock_q;
`endif

  sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d_i   (locked),
    .q_o   (lock_s)
  );

  // Channel i is released on the edge where the counter ends its stagger slot.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rel_hit = '0;
    for (int i = 0; i < NUM_RST; i++) begin
      rel_hit[i] = (cnt_q == CW'((i + 1) * STAGGER - 1));
    end
  end

  assign lock_lost = !lock_s && (state_q == RELEASE || state_q == RUN);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      retry_q   <= '0;
`ifdef PLL_SEQ_RELOCK_CNT_EN
      relock_q  <= '0;
`endif
    end else if (lock_lost) begin
      // Lock dropped after a good lock: re-hold resets but do not touch the PLL.
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
`ifdef PLL_SEQ_RELOCK_CNT_EN
      if (relock_q != 16'hFFFF) relock_q <= relock_q + 16'd1;
`endif
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == PULSE_END) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_END) begin
            cnt_q <= '0;
            if (retry_q == RETRY_MAX) begin
              state_q   <= FAIL;
              fail_q    <= 1'b1;
              pll_rst_q <= 1'b0;
              rst_out_q <= '1;
            end else begin
              state_q   <= RESET_PLL;
              pll_rst_q <= 1'b1;
              retry_q   <= retry_q + 8'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_END) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          rst_out_q <= rst_out_q & ~rel_hit;
          if (rel_hit[NUM_RST-1]) begin
            state_q <= RUN;
            ready_q <= 1'b1;
            retry_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RUN, FAIL: ;
        default: begin
          state_q   <= RESET_PLL;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
          rst_out_q <= '1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = pll_rst_q;
  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
`ifdef PLL_SEQ_RELOCK_CNT_EN
  assign relock_cnt = relock_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus random
// lock patterns, compared every cycle against an elapsed-time phase model.
module tb_pll_lock_sequencer;

  localparam int NUM_RST      = 3;
  localparam int RST_PULSE    = 4;
  localparam int LOCK_TIMEOUT = 32;
  localparam int LOCK_STABLE  = 8;
  localparam int STAGGER      = 4;
  localparam int MAX_RETRY    = 2;

  localparam int P_PULSE = 0, P_WAIT = 1, P_STAB = 2, P_REL = 3, P_RUN = 4, P_FAIL = 5;

  logic               clkin = 1'b0;
  logic               rst_n = 1'b0;
  logic               locked = 1'b0;
  logic               pll_rst;
  logic [NUM_RST-1:0] rst_out;
  logic               ready;
  logic               fail;
  logic [7:0]         retry_cnt;
`ifdef PLL_SEQ_RELOCK_CNT_EN
  logic [15:0]        relock_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: current phase, edges spent in it, and the two raw lock
  // samples still travelling through the synchroniser.
  int m_ph, m_el, m_retry, m_relock;
  bit m_h1, m_h2;

  pll_lock_sequencer #(
    .NUM_RST(NUM_RST), .RST_PULSE(RST_PULSE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE(LOCK_STABLE), .STAGGER(STAGGER), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .rst_out   (rst_out),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt)
`ifdef PLL_SEQ_RELOCK_CNT_EN
    ,
    .relock_cnt(relock_cnt)
`endif
  );

  always #5 clkin = ~clkin;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rst_out();
    int rel;
    rel = 0;
    if (m_ph == P_REL) rel = m_el / STAGGER;
    else if (m_ph == P_RUN) rel = NUM_RST;
    return ((32'd1 << NUM_RST) - 32'd1) & ~((32'd1 << rel) - 32'd1);
  endfunction

  task automatic model_reset();
    m_ph = P_PULSE; m_el = 0; m_retry = 0; m_relock = 0;
    m_h1 = 1'b0; m_h2 = 1'b0;
  endtask

  // Advance the model by one clock edge at which raw lock is sampled as lk.
  task automatic model_edge(input bit lk);
    bit ls;
    ls = m_h2; m_h2 = m_h1; m_h1 = lk;
    case (m_ph)
      P_PULSE: begin
        m_el++;
        if (m_el == RST_PULSE) begin m_ph = P_WAIT; m_el = 0; end
      end
      P_WAIT: begin
        if (ls) begin
          m_ph = P_STAB; m_el = 0;
        end else begin
          m_el++;
          if (m_el == LOCK_TIMEOUT) begin
            m_el = 0;
            if (m_retry == MAX_RETRY) m_ph = P_FAIL;
            else begin m_retry++; m_ph = P_PULSE; end
          end
        end
      end
      P_STAB: begin
        if (!ls) begin
          m_ph = P_WAIT; m_el = 0;
        end else begin
          m_el++;
          if (m_el == LOCK_STABLE) begin m_ph = P_REL; m_el = 0; end
        end
      end
      P_REL, P_RUN: begin
        if (!ls) begin
          m_ph = P_WAIT; m_el = 0;
          if (m_relock < 65535) m_relock++;
        end else if (m_ph == P_REL) begin
          m_el++;
          if (m_el == NUM_RST * STAGGER) begin m_ph = P_RUN; m_retry = 0; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("pll_rst", pll_rst, (m_ph == P_PULSE));
    check("rst_out", rst_out, exp_rst_out());
    check("ready", ready, (m_ph == P_RUN));
    check("fail", fail, (m_ph == P_FAIL));
    check("retry_cnt", retry_cnt, m_retry);
`ifdef PLL_SEQ_RELOCK_CNT_EN
    check("relock_cnt", relock_cnt, m_relock);
`endif
  endtask

  // Called at a falling edge: drive lk, let one rising edge pass, compare.
  task automatic cycle(input bit lk);
    locked = lk;
    model_edge(lk);
    @(negedge clkin);
    compare_all();
  endtask

  // Called at a falling edge: asserts reset mid-cycle, checks asynchronously.
  task automatic apply_reset();
    #2;
    rst_n  = 1'b0;
    locked = 1'b0;
    model_reset();
    #1;
    check("async_rst_out", rst_out, (32'd1 << NUM_RST) - 32'd1);
    check("async_pll_rst", pll_rst, 1);
    check("async_retry", retry_cnt, 0);
    compare_all();
    @(negedge clkin);
    @(negedge clkin);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int guard;
    model_reset();
    @(negedge clkin);

    // Clean lock with latency measurement.
    apply_reset();
    repeat (10) cycle(1'b0);
    lat = 0;
    do begin
      cycle(1'b1);
      lat++;
    end while (rst_out[0] && lat < 100);
    check("lock_latency", lat, 2 + LOCK_STABLE + STAGGER + 1);
    repeat (NUM_RST * STAGGER) cycle(1'b1);
    check("clean_ready", ready, 1);

    // Loss of lock in RUN, then full re-release without a PLL pulse.
    repeat (3) cycle(1'b0);
    check("loss_rst_out", rst_out, 3'b111);
    check("loss_ready", ready, 0);
    repeat (40) cycle(1'b1);
    check("relock_ready", ready, 1);

    // Glitchy lock: STABLE must restart after a one-cycle drop.
    apply_reset();
    repeat (10) cycle(1'b0);
    repeat (5) cycle(1'b1);
    cycle(1'b0);
    repeat (40) cycle(1'b1);
    check("glitch_ready", ready, 1);

    // Lock never arrives: retries then terminal failure.
    apply_reset();
    repeat (130) cycle(1'b0);
    check("timeout_fail", fail, 1);
    check("timeout_retry", retry_cnt, MAX_RETRY);
    for (int i = 0; i < 30; i++) cycle(1'($urandom_range(0, 1)));
    check("fail_sticky", fail, 1);
    check("fail_rst_out", rst_out, 3'b111);

    // Lock arriving on the exact timeout cycle wins over the retry.
    apply_reset();
    guard = 0;
    while (!(m_ph == P_WAIT && m_retry == 1 && m_el == LOCK_TIMEOUT - 3) && guard < 200) begin
      cycle(1'b0);
      guard++;
    end
    check("simul_reached", (guard < 200), 1);
    repeat (4) cycle(1'b1);
    check("simul_retry", retry_cnt, 1);
    check("simul_pll_rst", pll_rst, 0);
    repeat (30) cycle(1'b1);
    check("simul_ready", ready, 1);

    // Reset while channels are partially released.
    apply_reset();
    guard = 0;
    while (m_retry != 1 && guard < 100) begin cycle(1'b0); guard++; end
    while (exp_rst_out() != 32'b110 && guard < 200) begin cycle(1'b1); guard++; end
    check("midrel_reached", rst_out, 3'b110);
    apply_reset();
    repeat (30) cycle(1'b1);

    // Random lock patterns, mostly locked with occasional drops.
    for (int ep = 0; ep < 4; ep++) begin
      apply_reset();
      for (int n = 0; n < 300;) begin
        bit lk;
        int len;
        lk  = ($urandom_range(0, 3) != 0);
        len = lk ? $urandom_range(1, 40) : $urandom_range(1, 6);
        for (int k = 0; k < len; k++) cycle(lk);
        n += len;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
